// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory load/store path:
// opcode encodings, controller states and byte-lane helpers (big-endian).
package mips_mem_pkg;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } lsu_state_e;

  // Byte 0 sits in bits [31:24], so lane shift is (3 - addr_lo) * 8.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [3:0]  op,
                                              input logic [1:0]  addr_lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = 8'(word >> {~addr_lo, 3'b000});
    h = 16'(word >> {~addr_lo[1], 4'b0000});
    case (op)
      OP_LB:   res = {{24{b[7]}}, b};
      OP_LBU:  res = {24'b0, b};
      OP_LH:   res = {{16{h[15]}}, h};
      OP_LHU:  res = {16'b0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] byte_lane_merge(input logic [31:0] word,
                                                  input logic [31:0] data,
                                                  input logic [3:0]  op,
                                                  input logic [1:0]  addr_lo);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] res;
    case (op)
      OP_SB: begin
        sh   = {~addr_lo, 3'b000};
        mask = 32'h0000_00FF << sh;
        res  = (word & ~mask) | ({24'b0, data[7:0]} << sh);
      end
      OP_SH: begin
        sh   = {~addr_lo[1], 4'b0000};
        mask = 32'h0000_FFFF << sh;
        res  = (word & ~mask) | ({16'b0, data[15:0]} << sh);
      end
      default: res = data;
    endcase
    return res;
  endfunction

  function automatic logic op_fault(input logic [3:0] op, input logic [1:0] addr_lo);
    logic f;
    case (op)
      OP_LB, OP_LBU:         f = 1'b0;
      OP_LH, OP_LHU, OP_SH:  f = addr_lo[0];
      OP_LW, OP_SW:          f = (addr_lo != 2'b00);
      OP_SB:                 f = 1'b0;
      default:               f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ls_align.sv
// Combinational byte-lane datapath: load extraction/extension and
// sub-word store merge into a previously read word.
module ls_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_store_data,
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  always_comb begin
    o_load_data = load_extend(i_word, i_op, i_addr_lo);
    o_merged    = byte_lane_merge(i_word, i_store_data, i_op, i_addr_lo);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store controller for the word-wide data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter bit WORD_INDEXED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] LoadData,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic        w_accept;
  logic        w_fault_in;
  logic [3:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_store_data;
  logic        r_fault;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_load_data;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_accept   = Req && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_fault_in = op_fault(Op, Addr[1:0]);

  ls_align u_align (
    .i_word       (MemReadData),
    .i_store_data (r_store_data),
    .i_op         (r_op),
    .i_addr_lo    (r_addr_lo),
    .o_load_data  (w_load),
    .o_merged     (w_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          if (w_fault_in)       w_next = ST_DONE;
          else if (Op == OP_SW) w_next = ST_WRITE;
          else                  w_next = ST_READ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_READ:  w_next = r_op[3] ? ST_WRITE : ST_DONE;
      ST_WRITE: w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so an asynchronous
  // reset drops them at once and they can never overlap.
  always_comb begin
    Busy         = (r_state == ST_READ) || (r_state == ST_WRITE);
    Done         = (r_state == ST_DONE);
    Fault        = (r_state == ST_DONE) && r_fault;
    MemRead      = (r_state == ST_READ);
    MemWrite     = (r_state == ST_WRITE);
    MemAddress   = r_mem_addr;
    MemWriteData = r_mem_wdata;
    LoadData     = r_load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op         <= '0;
      r_addr_lo    <= '0;
      r_store_data <= '0;
      r_fault      <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_load_data  <= '0;
    end else begin
      if (w_accept) begin
        r_op         <= Op;
        r_addr_lo    <= Addr[1:0];
        r_store_data <= StoreData;
        r_fault      <= w_fault_in;
        r_mem_addr   <= WORD_INDEXED ? {2'b00, Addr[31:2]} : {Addr[31:2], 2'b00};
        if (Op == OP_SW) r_mem_wdata <= StoreData;
      end
      if (r_state == ST_READ) begin
        if (r_op[3]) r_mem_wdata <= w_merged;
        else         r_load_data <= w_load;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller for the MIPS data memory: accepts one load/store request at a time from the MEM stage and drives the word-wide data-memory port (MemAddress, MemWriteData, MemWrite, MemRead, MemReadData).
- Word ops need a single memory access; sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Sits between the pipeline's MEM stage and the data-memory module; reports alignment and opcode faults without touching memory.

## Interface
Parameters:
- WORD_INDEXED, 1: 1 → MemAddress = Addr >> 2 (word index); 0 → MemAddress = {Addr[31:2], 2'b00}.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Req  in  1  request strobe; sampled only when the unit is ready (state IDLE or DONE)
- Op  in  4  low nibble of the MIPS opcode: LB 0000, LH 0001, LW 0011, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1011; Op[3] = store
- Addr  in  32  byte address
- StoreData  in  32  store source; the byte/halfword is taken from the low bits
- Busy  out  1  high while an accepted request is in progress (states READ, WRITE)
- Done  out  1  one-cycle completion pulse
- LoadData  out  32  extended load result; valid while Done=1 and held until the next Done
- Fault  out  1  qualifies Done: misaligned address or undefined Op; no memory access was made
- MemAddress  out  32  to data memory; registered
- MemWriteData  out  32  to data memory; registered
- MemWrite  out  1  to data memory; registered
- MemRead  out  1  to data memory; registered
- MemReadData  in  32  from data memory; combinational (asynchronous) read

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- Accept: Req=1 in IDLE or DONE. Op and Addr are latched, and MemAddress is set from Addr.
- Next state on accept:
  - Fault (LH/LHU/SH with Addr[0]≠0; LW/SW with Addr[1:0]≠0; undefined Op) → DONE, Fault=1.
  - Load, SB or SH → READ, MemRead=1.
  - SW → WRITE, MemWrite=1, MemWriteData=StoreData.
- READ: MemReadData is captured at the closing edge.
  - Load: extract, extend → LoadData, go to DONE.
  - SB/SH: merge the store field into the captured word → MemWriteData, MemWrite=1, go to WRITE.
- WRITE: memory commits at the closing edge; go to DONE.
- DONE: Done=1 for one cycle. Go to IDLE, or accept a new Req directly (back-to-back).
- MemRead/MemWrite are high only in READ/WRITE respectively; never both high together.
- Byte order is big-endian:
  - Byte at Addr[1:0]=0 is bits [31:24]; byte 3 is bits [7:0].
  - Halfword at Addr[1]=0 is bits [31:16].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Stores leave LoadData unchanged. Faulted requests leave LoadData unchanged.
- Req while Busy=1 is ignored (not queued).

## Timing
- Accept edge = edge 0.
- LW/LB/LH/LBU/LHU: READ in cycle 1; Done in cycle 2 (after edge 1).
- SW: WRITE in cycle 1; memory written at edge 1; Done in cycle 2.
- SB/SH: READ cycle 1, WRITE cycle 2, memory written at edge 2; Done in cycle 3.
- Fault: Done=1, Fault=1 in cycle 1.
- Reset values: every output 0 (Busy, Done, Fault, LoadData, MemAddress, MemWriteData, MemWrite, MemRead); state IDLE.
- Reset mid-operation: MemWrite/MemRead drop immediately (asynchronous). The pending RMW is abandoned with no write and no Done.
- Addr/Op/StoreData need only be valid at the accept edge.

## Structure
- Shared package `mips_mem_pkg`:
  - Op encodings (OP_LB…OP_SW)
  - FSM state enum
  - helper functions `byte_lane_merge` and `load_extend`
- One natural sub-module, `ls_align`: combinational extract/extend plus merge, parameter-free. The FSM lives in `load_store_unit`.

## Test plan
- LW Addr=0x0000_0010, mem[4]=0xDEAD_BEEF → MemRead in cycle 1 with MemAddress=4; Done in cycle 2 with LoadData=0xDEAD_BEEF, Fault=0.
- LB vs LBU at Addr=0x13 with mem[4]=0x1234_5680 → LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
- SB Addr=0x11, StoreData=0xAB, mem[4]=0x1122_3344 → READ, then WRITE with MemWriteData=0x11AB_3344; Done in cycle 3; mem[4]=0x11AB_3344.
- SW Addr=0x0000_0006 → Done+Fault in cycle 1; MemRead/MemWrite never asserted; LoadData unchanged.
- Back-to-back: SH (Addr=0x2, StoreData=0xBEEF) then LHU (Addr=0x2) with Req held through the DONE cycle → second accepted without an IDLE gap; LHU returns 0x0000_BEEF. Req pulsed during Busy is ignored.
- Reset asserted in the WRITE cycle of an SB → MemWrite=0 immediately; memory unchanged; no Done; the next LW completes normally.
